// File: rtl/gpio_uart_pkg.sv
// rtl/gpio_uart_pkg.sv - shared state encoding and register bit indices for gpio_uart_tx
package gpio_uart_pkg;

  // Transmit FSM states; PARITY only exists in the parity build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef GPIO_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // cpu_status bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_ACK     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_OVF     = 8;

  // cpu_ctrl bit positions
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_CLR_OVF = 1;

  // cpu_out write-strobe toggle position
  localparam int OUT_TOGGLE   = 8;

`ifdef GPIO_UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, async active-low reset
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// rtl/gpio_uart_tx.sv - GPIO-driven UART transmitter; GPIO_UART_TX_PARITY_EN adds even parity
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_out,
  input  logic [31:0] cpu_ctrl,
  output logic [31:0] cpu_status,
  output logic        tx
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic          tog_q;
  logic          ack_q;
  logic          ovf_q;
  logic          tx_q;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef GPIO_UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic          write_ev;
  logic          push;
  logic          pop;
  logic          tx_en;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [4:0]    count_ext;
  logic          unused_bits;

  assign unused_bits = ^{cpu_out[31:9], cpu_ctrl[31:2]};

  assign tx_en    = cpu_ctrl[CTRL_TX_EN];
  assign write_ev = cpu_out[OUT_TOGGLE] ^ tog_q;
  // Full is judged on the pre-pop state, so a same-cycle pop never rescues a push.
  assign push     = write_ev & ~fifo_full;
  assign pop      = (state == ST_IDLE) & tx_en & ~fifo_empty;
  assign tx       = tx_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (cpu_out[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Toggle edge detector, write acknowledge and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= 1'b0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tog_q <= cpu_out[OUT_TOGGLE];
      if (push) ack_q <= cpu_out[OUT_TOGGLE];
      if (write_ev && fifo_full)        ovf_q <= 1'b1;
      else if (cpu_ctrl[CTRL_CLR_OVF])  ovf_q <= 1'b0;
    end
  end

  // Frame sequencer: each non-idle state lasts CLKS_PER_BIT cycles per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef GPIO_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      if (pop) begin
        shreg    <= fifo_rdata;
`ifdef GPIO_UART_TX_PARITY_EN
        par_q    <= even_parity(fifo_rdata);
`endif
        baud_cnt <= BAUD_RELOAD;
        bit_cnt  <= '0;
        state    <= ST_START;
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - 1'b1;
    end else begin
      baud_cnt <= BAUD_RELOAD;
      case (state)
        ST_START: state <= ST_DATA;
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
`ifdef GPIO_UART_TX_PARITY_EN
            state   <= ST_PARITY;
`else
            state   <= ST_STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg >> 1;
          end
        end
`ifdef GPIO_UART_TX_PARITY_EN
        ST_PARITY: state <= ST_STOP;
`endif
        ST_STOP: begin
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: begin
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered serial line, one cycle behind the state that selects it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= 1'b1;
    end else begin
      case (state)
        ST_START:  tx_q <= 1'b0;
        ST_DATA:   tx_q <= shreg[0];
`ifdef GPIO_UART_TX_PARITY_EN
        ST_PARITY: tx_q <= par_q;
`endif
        default:   tx_q <= 1'b1;
      endcase
    end
  end

  assign count_ext = 5'(fifo_count);

  // Status word assembled purely from registered state.
  always_comb begin
    cpu_status                         = '0;
    cpu_status[STAT_BUSY]              = (state != ST_IDLE);
    cpu_status[STAT_FULL]              = fifo_full;
    cpu_status[STAT_EMPTY]             = fifo_empty;
    cpu_status[STAT_ACK]               = ack_q;
    cpu_status[STAT_CNT_LSB +: 4]      = count_ext[3:0];
    cpu_status[STAT_OVF]               = ovf_q;
  end

endmodule
